systolic_feeder: RTL and testbench

//  Front-end sequencer for the NxN weight-stationary MAC array. Buffers one NxN weight tile,

---
 rtl/systolic_feeder_pkg.sv | 24 ++
 rtl/systolic_feeder_if.sv | 39 +++
 rtl/systolic_feeder_skew_line.sv | 38 +++
 rtl/systolic_feeder.sv | 148 ++++++++++++++
 tb/tb_systolic_feeder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic array front-end feeder.
// Holds default dimensions, the sequencer state encoding and a lane slicer.
package systolic_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_BIT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WT_FILL,
        WT_LOAD,
        STREAM,
        DRAIN
    } feeder_state_e;

    // Element idx of a lane-packed vector at the default dimensions.
    function automatic logic [DEF_BIT_WIDTH-1:0] lane_slice(
        input logic [DEF_N*DEF_BIT_WIDTH-1:0] vec,
        input int unsigned                    idx
    );
        return vec[idx*DEF_BIT_WIDTH +: DEF_BIT_WIDTH];
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and array-facing bundle of the systolic feeder.
// slave is the feeder side, master is the source/array side.
interface systolic_feeder_if #(
    parameter int N         = 4,
    parameter int BIT_WIDTH = 8
);
    logic                   wt_valid_i;
    logic                   wt_ready_o;
    logic [N*BIT_WIDTH-1:0] wt_row_i;
    logic                   act_valid_i;
    logic                   act_ready_o;
    logic [N*BIT_WIDTH-1:0] act_vec_i;
    logic                   act_last_i;
    logic [N*BIT_WIDTH-1:0] wt_col_o;
    logic                   wt_ctrl_o;
    logic [N*BIT_WIDTH-1:0] act_row_o;
    logic [N-1:0]           act_vld_o;
    logic                   busy_o;
    logic                   done_o;

    modport slave (
        input  wt_valid_i, wt_row_i,
        input  act_valid_i, act_vec_i, act_last_i,
        output wt_ready_o, act_ready_o,
        output wt_col_o, wt_ctrl_o,
        output act_row_o, act_vld_o,
        output busy_o, done_o
    );

    modport master (
        output wt_valid_i, wt_row_i,
        output act_valid_i, act_vec_i, act_last_i,
        input  wt_ready_o, act_ready_o,
        input  wt_col_o, wt_ctrl_o,
        input  act_row_o, act_vld_o,
        input  busy_o, done_o
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth register delay line carrying one lane's data and valid.
// Stage 0 captures the input; the last stage drives the output.
module skew_line #(
    parameter int DEPTH     = 1,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] d_i,
    input  logic                 v_i,
    output logic [BIT_WIDTH-1:0] d_o,
    output logic                 v_o
);

    logic [BIT_WIDTH-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0]     vld_q;

    // Shift data and valid one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            dat_q[0] <= d_i;
            vld_q[0] <= v_i;
            for (int i = 1; i < DEPTH; i++) begin
                dat_q[i] <= dat_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign d_o = dat_q[DEPTH-1];
    assign v_o = vld_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight-tile loader and skewed activation streamer for an NxN array.
// Bottom weight row is shifted first; lane r is delayed r+1 cycles.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input logic         clk,
    input logic         rst,
    systolic_feeder_if.slave bus
);

    localparam int            RW   = N * BIT_WIDTH;
    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    feeder_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] bank_q [N];
    logic [RW-1:0] col_q;
    logic          ctrl_q;
    logic          wt_rdy_q;
    logic          act_rdy_q;
    logic          busy_q;
    logic          done_q;

    logic          wt_acc;
    logic          act_acc;
    logic [RW-1:0] next_row;
    logic [RW-1:0] skew_d;
    logic [RW-1:0] row_w;
    logic [N-1:0]  vld_w;

    assign wt_acc  = bus.wt_valid_i & wt_rdy_q;
    assign act_acc = bus.act_valid_i & act_rdy_q;
    assign skew_d  = act_acc ? bus.act_vec_i : '0;

    // Bank row presented on the load cycle after the current one.
    always_comb begin
        next_row = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == LAST - CW'(1) - cnt_q) begin
                next_row = bank_q[i];
            end
        end
    end

    // Sequencer: state, counters, weight bank and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            ctrl_q    <= 1'b0;
            wt_rdy_q  <= 1'b0;
            act_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE, WT_FILL: begin
                    wt_rdy_q <= 1'b1;
                    if (wt_acc) begin
                        for (int i = 0; i < N; i++) begin
                            if (CW'(i) == cnt_q) begin
                                bank_q[i] <= bus.wt_row_i;
                            end
                        end
                        busy_q <= 1'b1;
                        if (cnt_q == LAST) begin
                            state_q  <= WT_LOAD;
                            cnt_q    <= '0;
                            wt_rdy_q <= 1'b0;
                            ctrl_q   <= 1'b1;
                            col_q    <= bus.wt_row_i;
                        end else begin
                            state_q <= WT_FILL;
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                end
                WT_LOAD: begin
                    if (cnt_q == LAST) begin
                        state_q   <= STREAM;
                        cnt_q     <= '0;
                        ctrl_q    <= 1'b0;
                        col_q     <= '0;
                        act_rdy_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        col_q <= next_row;
                    end
                end
                STREAM: begin
                    if (act_acc && bus.act_last_i) begin
                        state_q   <= DRAIN;
                        cnt_q     <= '0;
                        act_rdy_q <= 1'b0;
                        done_q    <= (LAST == '0);
                    end
                end
                DRAIN: begin
                    if (cnt_q == LAST) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        wt_rdy_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        done_q <= (cnt_q + CW'(1) == LAST);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        skew_line #(
            .DEPTH     (r + 1),
            .BIT_WIDTH (BIT_WIDTH)
        ) u_skew (
            .clk (clk),
            .rst (rst),
            .d_i (skew_d[r*BIT_WIDTH +: BIT_WIDTH]),
            .v_i (act_acc),
            .d_o (row_w[r*BIT_WIDTH +: BIT_WIDTH]),
            .v_o (vld_w[r])
        );
    end

    assign bus.wt_ready_o  = wt_rdy_q;
    assign bus.act_ready_o = act_rdy_q;
    assign bus.wt_col_o    = col_q;
    assign bus.wt_ctrl_o   = ctrl_q;
    assign bus.act_row_o   = row_w;
    assign bus.act_vld_o   = vld_w;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a weight-stationary MAC model.
// Each check is an immediate assertion against hand-derived values.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int RW = N * BW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .BIT_WIDTH(BW)) bus();

    systolic_feeder #(.N(N), .BIT_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] tile [N];
    logic [BW-1:0] amat [8][N];
    int            base [N];

    logic [BW-1:0] pe_w  [N][N] = '{default: '0};
    logic [BW-1:0] a_r   [N][N] = '{default: '0};
    logic          av_r  [N][N] = '{default: 1'b0};
    int            ps_r  [N][N] = '{default: 0};
    logic          pv_r  [N][N] = '{default: 1'b0};
    int            col_res [N][64] = '{default: 0};
    int            col_n [N] = '{default: 0};

    // MAC array model: weights shift down, activations right, sums down.
    always @(posedge clk) begin : array_model
        logic [BW-1:0] a_in;
        logic          v_in;
        int            p_in;
        logic          pv_in;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_in  = (c == 0) ? lane_slice(bus.act_row_o, r) : a_r[r][c-1];
                v_in  = (c == 0) ? bus.act_vld_o[r] : av_r[r][c-1];
                p_in  = (r == 0) ? 0 : ps_r[r-1][c];
                pv_in = (r == 0) ? v_in : pv_r[r-1][c];
                a_r[r][c]  <= a_in;
                av_r[r][c] <= v_in;
                ps_r[r][c] <= p_in + int'(pe_w[r][c]) * int'(a_in);
                pv_r[r][c] <= pv_in;
                if (bus.wt_ctrl_o) begin
                    pe_w[r][c] <= (r == 0) ? lane_slice(bus.wt_col_o, c)
                                           : pe_w[r-1][c];
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            if (pv_r[N-1][c] && col_n[c] < 64) begin
                col_res[c][col_n[c]] <= ps_r[N-1][c];
                col_n[c] <= col_n[c] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] pack4(input int e0, input int e1,
                                            input int e2, input int e3);
        return {BW'(e3), BW'(e2), BW'(e1), BW'(e0)};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_wrdy"}, 64'(bus.wt_ready_o), 64'(0));
        chk({tag, "_ardy"}, 64'(bus.act_ready_o), 64'(0));
        chk({tag, "_col"}, 64'(bus.wt_col_o), 64'(0));
        chk({tag, "_ctrl"}, 64'(bus.wt_ctrl_o), 64'(0));
        chk({tag, "_row"}, 64'(bus.act_row_o), 64'(0));
        chk({tag, "_vld"}, 64'(bus.act_vld_o), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
        chk({tag, "_done"}, 64'(bus.done_o), 64'(0));
    endtask

    task automatic load_tile(input string tag);
        for (int r = 0; r < N; r++) begin
            bus.wt_valid_i = 1'b1;
            bus.wt_row_i   = tile[r];
            chk({tag, "_fill_rdy"}, 64'(bus.wt_ready_o), 64'(1));
            tick();
            chk({tag, "_fill_busy"}, 64'(bus.busy_o), 64'(1));
        end
        bus.wt_valid_i = 1'b0;
        bus.wt_row_i   = '0;
        for (int k = 0; k < N; k++) begin
            chk({tag, "_ld_ctrl"}, 64'(bus.wt_ctrl_o), 64'(1));
            chk({tag, "_ld_col"}, 64'(bus.wt_col_o), 64'(tile[N-1-k]));
            chk({tag, "_ld_rdy"}, 64'(bus.wt_ready_o), 64'(0));
            tick();
        end
        chk({tag, "_ld_end_ctrl"}, 64'(bus.wt_ctrl_o), 64'(0));
        chk({tag, "_ld_end_col"}, 64'(bus.wt_col_o), 64'(0));
        chk({tag, "_stream_ardy"}, 64'(bus.act_ready_o), 64'(1));
    endtask

    initial begin
        logic [RW-1:0] va;
        logic [RW-1:0] vc;
        logic [RW-1:0] er;
        logic [N-1:0]  ev;
        int            lim;
        bit            got;

        rst             = 1'b1;
        bus.wt_valid_i  = 1'b0;
        bus.wt_row_i    = '0;
        bus.act_valid_i = 1'b0;
        bus.act_vec_i   = '0;
        bus.act_last_i  = 1'b0;

        // Reset state and first cycle after release.
        tick();
        tick();
        chk_quiet("rst");
        rst = 1'b0;
        tick();
        chk("idle_wrdy", 64'(bus.wt_ready_o), 64'(1));
        chk("idle_busy", 64'(bus.busy_o), 64'(0));
        chk("idle_ardy", 64'(bus.act_ready_o), 64'(0));

        // Tile W[r][c] = 4r+c+1, bottom row first.
        for (int r = 0; r < N; r++) begin
            tile[r] = pack4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
        end
        load_tile("w");
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("pe_%0d_%0d", r, c), 64'(pe_w[r][c]),
                    64'(4*r+c+1));
            end
        end

        // Weight offer during STREAM is ignored.
        bus.wt_valid_i = 1'b1;
        bus.wt_row_i   = '1;
        chk("strm_wrdy", 64'(bus.wt_ready_o), 64'(0));
        tick();
        bus.wt_valid_i = 1'b0;
        bus.wt_row_i   = '0;
        chk("strm_ctrl", 64'(bus.wt_ctrl_o), 64'(0));
        chk("strm_col", 64'(bus.wt_col_o), 64'(0));
        chk("strm_busy", 64'(bus.busy_o), 64'(1));
        chk("strm_pe00", 64'(pe_w[0][0]), 64'(1));
        chk("strm_pe33", 64'(pe_w[3][3]), 64'(16));

        // Valid pattern 1,0,1: bubble rides between two skewed vectors.
        va = pack4(5, 6, 7, 8);
        vc = pack4(9, 10, 11, 12);
        bus.act_valid_i = 1'b1;
        bus.act_vec_i   = va;
        tick();
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) bus.act_valid_i = 1'b0;
            if (k == 2) begin
                bus.act_valid_i = 1'b1;
                bus.act_vec_i   = vc;
                bus.act_last_i  = 1'b1;
            end
            if (k == 3) begin
                bus.act_valid_i = 1'b0;
                bus.act_vec_i   = '0;
                bus.act_last_i  = 1'b0;
            end
            er = '0;
            ev = '0;
            for (int r = 0; r < N; r++) begin
                if (k == 1 + r) begin
                    er[r*BW +: BW] = lane_slice(va, r);
                    ev[r] = 1'b1;
                end
                if (k == 3 + r) begin
                    er[r*BW +: BW] = lane_slice(vc, r);
                    ev[r] = 1'b1;
                end
            end
            chk($sformatf("gap_row_c%0d", k), 64'(bus.act_row_o), 64'(er));
            chk($sformatf("gap_vld_c%0d", k), 64'(bus.act_vld_o), 64'(ev));
            chk($sformatf("gap_done_c%0d", k), 64'(bus.done_o), 64'(k == 6));
            chk($sformatf("gap_ardy_c%0d", k), 64'(bus.act_ready_o), 64'(k <= 2));
            chk($sformatf("gap_busy_c%0d", k), 64'(bus.busy_o), 64'(k <= 6));
            chk($sformatf("gap_wrdy_c%0d", k), 64'(bus.wt_ready_o), 64'(k == 7));
            tick();
        end

        // Identity tile, single last vector {1,2,3,4}.
        for (int r = 0; r < N; r++) begin
            tile[r] = '0;
            tile[r][r*BW +: BW] = 8'd1;
        end
        load_tile("id");
        bus.act_valid_i = 1'b1;
        bus.act_vec_i   = pack4(1, 2, 3, 4);
        bus.act_last_i  = 1'b1;
        tick();
        bus.act_valid_i = 1'b0;
        bus.act_vec_i   = '0;
        bus.act_last_i  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            er = '0;
            ev = '0;
            for (int r = 0; r < N; r++) begin
                if (k == r + 1) begin
                    er[r*BW +: BW] = BW'(r + 1);
                    ev[r] = 1'b1;
                end
            end
            chk($sformatf("one_row_c%0d", k), 64'(bus.act_row_o), 64'(er));
            chk($sformatf("one_vld_c%0d", k), 64'(bus.act_vld_o), 64'(ev));
            chk($sformatf("one_done_c%0d", k), 64'(bus.done_o), 64'(k == 4));
            chk($sformatf("one_busy_c%0d", k), 64'(bus.busy_o), 64'(k <= 4));
            tick();
        end
        repeat (10) tick();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("one_acc_col%0d", c),
                64'(col_res[c][col_n[c] > 0 ? col_n[c] - 1 : 0]), 64'(c + 1));
            base[c] = col_n[c];
        end

        // End-to-end: identity weights, 8 random vectors back to back.
        load_tile("e2e");
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < N; c++) begin
                amat[j][c] = BW'($urandom_range(0, 255));
            end
        end
        for (int j = 0; j < 8; j++) begin
            bus.act_valid_i = 1'b1;
            bus.act_vec_i   = {amat[j][3], amat[j][2], amat[j][1], amat[j][0]};
            bus.act_last_i  = (j == 7);
            tick();
        end
        bus.act_valid_i = 1'b0;
        bus.act_vec_i   = '0;
        bus.act_last_i  = 1'b0;
        lim = 0;
        got = 1'b0;
        while (!got && lim < 60) begin
            got = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (col_n[c] - base[c] < 8) got = 1'b0;
            end
            if (!got) tick();
            lim++;
        end
        chk("e2e_all_out", 64'(got), 64'(1));
        for (int c = 0; c < N; c++) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("e2e_v%0d_c%0d", j, c),
                    64'(col_res[c][base[c] + j]), 64'(amat[j][c]));
            end
        end

        // Reset pulse in the middle of STREAM with data in the skew.
        for (int r = 0; r < N; r++) begin
            tile[r] = pack4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
        end
        load_tile("ab");
        bus.act_valid_i = 1'b1;
        bus.act_vec_i   = pack4(1, 1, 1, 1);
        tick();
        bus.act_valid_i = 1'b0;
        bus.act_vec_i   = '0;
        chk("ab_pre_vld", 64'(bus.act_vld_o), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("ab_rst");
        tick();
        rst = 1'b0;
        tick();
        chk("ab_wrdy", 64'(bus.wt_ready_o), 64'(1));
        chk("ab_busy", 64'(bus.busy_o), 64'(0));
        chk("ab_ardy", 64'(bus.act_ready_o), 64'(0));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("ab_vld_%0d", k), 64'(bus.act_vld_o), 64'(0));
            chk($sformatf("ab_row_%0d", k), 64'(bus.act_row_o), 64'(0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
